// File: rtl/seq_comparator.sv
// Sequential magnitude comparator: CHUNK bits per cycle, MSB slice first, signed or unsigned.
// Optional macro SEQCMP_EARLY_EXIT_EN ends the run as soon as a differing slice has been seen.
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic             tc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_shl_d, b_shl_d;
  logic [IW-1:0]    idx_q;
  logic             g_q, l_q;
  logic             g_d, l_d;
  logic             last_slice, finish;
  logic             busy_q, done_q, gt_q, lt_q, eq_q;

  // Operands shift left one slice per RUN cycle so the current slice is always the top CHUNK bits.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign a_shl_d = a_q;
      assign b_shl_d = b_q;
    end else begin : g_multi
      assign a_shl_d = {a_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
      assign b_shl_d = {b_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
    end
  endgenerate

  always_comb begin
    g_d = g_q;
    l_d = l_q;
    for (int i = WIDTH - 1; i >= WIDTH - CHUNK; i--) begin
      {g_d, l_d} = {g_d | (~l_d & a_q[i] & ~b_q[i]),
                    l_d | (~g_d & ~a_q[i] & b_q[i])};
    end
  end

  assign last_slice = (idx_q == LAST_IDX);

`ifdef SEQCMP_EARLY_EXIT_EN
  assign finish = last_slice | g_d | l_d;
`else
  assign finish = last_slice;
`endif

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q     <= {a[WIDTH-1] ^ tc, a[WIDTH-2:0]};
            b_q     <= {b[WIDTH-1] ^ tc, b[WIDTH-2:0]};
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_shl_d;
          b_q   <= b_shl_d;
          g_q   <= g_d;
          l_q   <= l_d;
          idx_q <= idx_q + IW'(1);
          if (finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            gt_q    <= g_d;
            lt_q    <= l_d;
            eq_q    <= ~(g_d | l_d);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;
endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: directed vectors on a 16/4 instance checked cycle by cycle against
// an arithmetic model, plus exhaustive 4-bit sweeps at CHUNK=1 and CHUNK=2.
`timescale 1ns/1ps
module tb_seq_comparator;
  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  logic         clock = 1'b0;
  logic         reset_L = 1'b0;
  logic         start = 1'b0;
  logic         tc = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, gt, lt, eq;

  logic         sw_start = 1'b0;
  logic         sw_tc = 1'b0;
  logic [3:0]   sw_a = '0;
  logic [3:0]   sw_b = '0;
  logic         busy1, done1, gt1, lt1, eq1;
  logic         busy2, done2, gt2, lt2, eq2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seq_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .tc(tc), .a(a), .b(b),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq)
  );

  seq_comparator #(.WIDTH(4), .CHUNK(1)) dut_c1 (
    .clock(clock), .reset_L(reset_L), .start(sw_start), .tc(sw_tc), .a(sw_a), .b(sw_b),
    .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1)
  );

  seq_comparator #(.WIDTH(4), .CHUNK(2)) dut_c2 (
    .clock(clock), .reset_L(reset_L), .start(sw_start), .tc(sw_tc), .a(sw_a), .b(sw_b),
    .busy(busy2), .done(done2), .gt(gt2), .lt(lt2), .eq(eq2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: latency is NCHUNK, or the first differing slice + 1 with early exit enabled.
  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    int first_diff = NC;
    int lat;
    for (int j = NC - 1; j >= 0; j--) begin
      if (((x >> (W - C * (j + 1))) & ((1 << C) - 1)) != ((y >> (W - C * (j + 1))) & ((1 << C) - 1)))
        first_diff = j;
    end
`ifdef SEQCMP_EARLY_EXIT_EN
    lat = (first_diff < NC) ? first_diff + 1 : NC;
`else
    lat = (first_diff < NC) ? NC : NC;
`endif
    return lat;
  endfunction

  int   acc = -1;
  int   m_lat = NC;
  logic m_gt = 1'b0, m_lt = 1'b0, m_eq = 1'b0;
  logic o_gt = 1'b0, o_lt = 1'b0, o_eq = 1'b0;
  logic exp_busy, exp_done;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset_L && start && (acc < 0 || cyc - 1 >= acc + m_lat + 1)) begin
      acc   = cyc;
      m_lat = model_lat(a, b);
      if (tc) begin
        m_gt = $signed(a) > $signed(b);
        m_lt = $signed(a) < $signed(b);
      end else begin
        m_gt = a > b;
        m_lt = a < b;
      end
      m_eq = (a == b);
    end
  end

  always @(negedge reset_L) begin
    acc  = -1;
    o_gt = 1'b0;
    o_lt = 1'b0;
    o_eq = 1'b0;
  end

  always @(negedge clock) begin
    exp_done = (acc >= 0) && (cyc == acc + m_lat);
    exp_busy = (acc >= 0) && (cyc >= acc) && (cyc <= acc + m_lat);
    if (exp_done) begin
      o_gt = m_gt;
      o_lt = m_lt;
      o_eq = m_eq;
    end
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("gt_lt_eq", {gt, lt, eq}, {o_gt, o_lt, o_eq});
  end

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!done && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (n >= 50) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic run_cmp(input string nm, input logic t, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2:0] exp_res, input int lat_full, input int lat_ee);
    int n;
    int el;
`ifdef SEQCMP_EARLY_EXIT_EN
    el = lat_ee;
`else
    el = lat_full;
`endif
    tc = t; a = x; b = y; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(nm, n);
    chk({nm, "_lat"}, n, el);
    chk({nm, "_res"}, {gt, lt, eq}, exp_res);
    $display("cmp %s tc=%0d a=%h b=%h -> gt=%0d lt=%0d eq=%0d latency=%0d",
             nm, t, x, y, gt, lt, eq, n);
    @(negedge clock);
  endtask

  initial begin
    int n;
    int dones;
    int seen;
    logic [2:0] res;
    logic [2:0] r1, r2, rref;
    logic got1, got2;

    repeat (2) @(negedge clock);
    chk("reset_outs", {busy, done, gt, lt, eq}, 5'b0);
    reset_L = 1'b1;
    @(negedge clock);

    run_cmp("u_8000_7fff",  1'b0, 16'h8000, 16'h7FFF, 3'b100, 4, 1);
    run_cmp("s_8000_7fff",  1'b1, 16'h8000, 16'h7FFF, 3'b010, 4, 1);
    run_cmp("s_ffff_fffe",  1'b1, 16'hFFFF, 16'hFFFE, 3'b100, 4, 4);
    run_cmp("u_a5a5_a5a5",  1'b0, 16'hA5A5, 16'hA5A5, 3'b001, 4, 4);
    run_cmp("s_7fff_8000",  1'b1, 16'h7FFF, 16'h8000, 3'b100, 4, 1);
    run_cmp("u_0010_0011",  1'b0, 16'h0010, 16'h0011, 3'b010, 4, 4);
    run_cmp("s_fff0_0005",  1'b1, 16'hFFF0, 16'h0005, 3'b010, 4, 1);
    run_cmp("u_1234_1284",  1'b0, 16'h1234, 16'h1284, 3'b010, 4, 3);

    // start held high through the whole compare while a changes underneath it
    tc = 1'b0; a = 16'h0001; b = 16'h0002; start = 1'b1;
    @(negedge clock);
    a = 16'hFFFF;
    dones = 0;
    res = 3'b000;
    for (int i = 0; i < NC + 1; i++) begin
      @(negedge clock);
      if (done) begin
        dones++;
        res = {gt, lt, eq};
      end
    end
    chk("hold_single_done", dones, 1);
    chk("hold_res", res, 3'b010);
    chk("hold_idle_gap", busy, 1'b0);
    @(negedge clock);
    start = 1'b0;
    chk("hold_reaccept", busy, 1'b1);
    $display("cmp hold tc=0 a=0001 b=0002 -> dones=%0d gt/lt/eq=%b, re-accepted a=ffff", dones, res);
    wait_done("hold_second", n);
    chk("hold_second_res", {gt, lt, eq}, 3'b100);
    @(negedge clock);

    // reset during the second RUN cycle aborts the compare
    tc = 1'b0; a = 16'h0005; b = 16'h0009; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #1 reset_L = 1'b0;
    #1 chk("abort_outs", {busy, done, gt, lt, eq}, 5'b0);
    #1 reset_L = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    $display("cmp abort tc=0 a=0005 b=0009 -> reset in RUN, done pulses=%0d", seen);
    run_cmp("u_0003_0003", 1'b0, 16'h0003, 16'h0003, 3'b001, 4, 4);

    for (int t = 0; t < 2; t++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          sw_tc = t[0]; sw_a = x[3:0]; sw_b = y[3:0]; sw_start = 1'b1;
          @(negedge clock);
          sw_start = 1'b0;
          got1 = 1'b0; got2 = 1'b0; r1 = 3'b000; r2 = 3'b000; n = 0;
          while (!(got1 && got2) && n < 10) begin
            @(negedge clock);
            n++;
            if (done1 && !got1) begin got1 = 1'b1; r1 = {gt1, lt1, eq1}; end
            if (done2 && !got2) begin got2 = 1'b1; r2 = {gt2, lt2, eq2}; end
          end
          if (t == 1)
            rref = {$signed(sw_a) > $signed(sw_b), $signed(sw_a) < $signed(sw_b), sw_a == sw_b};
          else
            rref = {sw_a > sw_b, sw_a < sw_b, sw_a == sw_b};
          chk("sweep_c1", {got1, r1}, {1'b1, rref});
          chk("sweep_c2", {got2, r2}, {1'b1, rref});
          $display("sweep tc=%0d a=%h b=%h -> c1=%b c2=%b ref=%b", t, sw_a, sw_b, r1, r2, rref);
          @(negedge clock);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
